// File: rtl/mem_port_arbiter.sv
// Purpose : shares one fixed-latency memory port between the CPU (port 0) and the loader/debug port (port 1).
// Latency : gnt one cycle after req is seen in IDLE; done MEM_LATENCY cycles after gnt; one idle cycle between accesses.
// Backpr. : a req arriving while busy is held off until IDLE; the losing requester keeps req high and waits.
//
// Ports:
//   clk, reset                           clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt/done/rdata   CPU request and response
//   ldr_req/we/addr/wdata -> ldr_gnt/done/rdata   loader request and response
//   mem_en/we/addr/wdata, mem_rdata               memory-side port
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner on simultaneous requests;
// without it the CPU always wins a tie.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_LDR  = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              win_ldr;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, hand the port to whichever side did not own it last time.
    assign win_ldr = (cpu_req && ldr_req) ? (last_owner_q == OWN_CPU) : ldr_req;
`else
    assign win_ldr = ldr_req && !cpu_req;
    // Ownership history is still kept so both builds share one state machine.
    logic last_owner_unused;
    assign last_owner_unused = last_owner_q;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || ldr_req) begin
                    state_d = S_ACCESS;
                    owner_d = win_ldr;
                    we_d    = win_ldr ? ldr_we    : cpu_we;
                    addr_d  = win_ldr ? ldr_addr  : cpu_addr;
                    wdata_d = win_ldr ? ldr_wdata : cpu_wdata;
                end
            end
            S_ACCESS: begin
                cnt_d   = CNT_INIT;
                state_d = (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!we_q) begin
                    if (owner_q == OWN_LDR) begin
                        ldr_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_LDR;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 4'd0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    logic resp_rd;
    assign resp_rd = (state_q == S_RESP) && !we_q;

    assign mem_en    = (state_q == S_ACCESS);
    assign mem_we    = (state_q == S_ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_gnt  = (state_q == S_ACCESS) && (owner_q == OWN_CPU);
    assign ldr_gnt  = (state_q == S_ACCESS) && (owner_q == OWN_LDR);
    assign cpu_done = (state_q == S_RESP)   && (owner_q == OWN_CPU);
    assign ldr_done = (state_q == S_RESP)   && (owner_q == OWN_LDR);

    // Read data is only valid on mem_rdata during RESP, so it is forwarded in
    // the done cycle and the register holds it from then on.
    assign cpu_rdata = (resp_rd && owner_q == OWN_CPU) ? mem_rdata : cpu_rdata_q;
    assign ldr_rdata = (resp_rd && owner_q == OWN_LDR) ? mem_rdata : ldr_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic        cpu_gnt, cpu_done, ldr_gnt, ldr_done;
    logic [31:0] cpu_rdata, ldr_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // second instance, latency 1
    logic        c1_req, c1_we, l1_req, l1_we;
    logic [31:0] c1_addr, c1_wdata, l1_addr, l1_wdata;
    logic        c1_gnt, c1_done, l1_gnt, l1_done;
    logic [31:0] c1_rdata, l1_rdata;
    logic        m1_en, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic [31:0] m1_rdata = 32'd0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
        .cpu_gnt(c1_gnt), .cpu_done(c1_done), .cpu_rdata(c1_rdata),
        .ldr_req(l1_req), .ldr_we(l1_we), .ldr_addr(l1_addr), .ldr_wdata(l1_wdata),
        .ldr_gnt(l1_gnt), .ldr_done(l1_done), .ldr_rdata(l1_rdata),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [159:0] act_vec();
        return {26'd0, cpu_gnt, ldr_gnt, cpu_done, ldr_done, mem_en, mem_we,
                mem_addr, mem_wdata, cpu_rdata, ldr_rdata};
    endfunction

    // Fixed-latency memory for the main instance: data for an access strobed in
    // cycle k appears on mem_rdata in cycle k+LAT.
    logic [31:0] mem_arr [256];
    logic [31:0] pipe [LAT];
    bit          mem_loaded = 1'b0;
    assign mem_rdata = pipe[LAT-1];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= (i == 16) ? 32'hDEADBEEF : 32'h0;
            mem_loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
        end
        pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[7:0]] : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    // Latency-1 memory for the second instance: returns a tag of the address.
    always @(posedge clk) m1_rdata <= {16'hCAFE, m1_addr[15:0]};

    // Transaction-level model: a transaction accepted at the end of cycle c is
    // granted in c+1, completes in c+1+LAT, and the port is free from c+2+LAT.
    bit          m_valid = 1'b0, m_init = 1'b0;
    int          m_gnt_c = -1, m_done_c = -1, m_free_c = 0;
    bit          m_owner, m_last, m_we;
    logic [31:0] m_addr, m_wdata, m_exp_rd, m_cpu_rd, m_ldr_rd;
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin : model
        int c;
        bit w;
        c = cyc;
        if (!m_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
            ref_mem[16] = 32'hDEADBEEF;
            m_init = 1'b1;
        end
        if (reset) begin
            m_valid = 1'b1; m_gnt_c = -1; m_done_c = -1; m_free_c = c + 1;
            m_owner = 1'b0; m_last = 1'b1; m_we = 1'b0;
            m_addr = 32'h0; m_wdata = 32'h0; m_cpu_rd = 32'h0; m_ldr_rd = 32'h0;
        end else if (m_valid) begin
            if (c == m_done_c) begin
                if (!m_we) begin
                    if (m_owner) m_ldr_rd = m_exp_rd;
                    else         m_cpu_rd = m_exp_rd;
                end
                m_last = m_owner;
            end
            if (c >= m_free_c && (cpu_req || ldr_req)) begin
                if (cpu_req && ldr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = ~m_last;
`else
                    w = 1'b0;
`endif
                end else begin
                    w = ldr_req;
                end
                m_owner = w;
                m_we    = w ? ldr_we    : cpu_we;
                m_addr  = w ? ldr_addr  : cpu_addr;
                m_wdata = w ? ldr_wdata : cpu_wdata;
                m_gnt_c  = c + 1;
                m_done_c = c + 1 + LAT;
                m_free_c = m_done_c + 1;
                if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                else      m_exp_rd = ref_mem[m_addr[7:0]];
            end
        end
    end

    // Per-cycle comparison of every main-instance output against the model.
    always @(negedge clk) begin : compare
        int c;
        bit e_en, e_rd_cpu, e_rd_ldr;
        logic [31:0] e_cr, e_lr;
        c = cyc;
        if (m_valid) begin
            e_en     = (c == m_gnt_c);
            e_rd_cpu = (c == m_done_c) && !m_owner && !m_we;
            e_rd_ldr = (c == m_done_c) &&  m_owner && !m_we;
            e_cr = e_rd_cpu ? m_exp_rd : m_cpu_rd;
            e_lr = e_rd_ldr ? m_exp_rd : m_ldr_rd;
            check_vec("cycle_outputs", act_vec(),
                      {26'd0, e_en && !m_owner, e_en && m_owner,
                       (c == m_done_c) && !m_owner, (c == m_done_c) && m_owner,
                       e_en, e_en && m_we, m_addr, m_wdata, e_cr, e_lr});
        end
    end

    // Event recorder for the hand-computed checks.
    int cpu_gnt_cyc = -1, cpu_done_cyc = -1, ldr_gnt_cyc = -1, ldr_done_cyc = -1;
    int mem_we_cyc = -1, mem_en_cnt = 0;
    bit gnt_q[$];
    always @(negedge clk) begin
        if (cpu_gnt)  begin cpu_gnt_cyc = cyc; gnt_q.push_back(1'b0); end
        if (ldr_gnt)  begin ldr_gnt_cyc = cyc; gnt_q.push_back(1'b1); end
        if (cpu_done) cpu_done_cyc = cyc;
        if (ldr_done) ldr_done_cyc = cyc;
        if (mem_en)   mem_en_cnt++;
        if (mem_en && mem_we) mem_we_cyc = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on the main instance; returns the cycle in which req was raised.
    task automatic do_txn(input bit ldr, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int c0);
        c0 = cyc;
        if (ldr) begin ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; end
        else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        tick();
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    bit exp_order [4];

    initial begin
        int c0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0;
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = 32'h0; c1_wdata = 32'h0;
        l1_req = 1'b0; l1_we = 1'b0; l1_addr = 32'h0; l1_wdata = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        tick();
        tick();
        check_vec("reset_state", act_vec(), 160'd0);
        reset = 1'b0;

        // Both requesters held high across four transactions.
        gnt_q.delete();
        c0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h20;
        repeat (13) tick();
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        repeat (3) tick();
        check("arb_grant_count", 32'(gnt_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_q.size()) check($sformatf("arb_order%0d", i), 32'(gnt_q[i]), 32'(exp_order[i]));

        // CPU read of 0x10.
        mem_en_cnt = 0;
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, c0);
        check("cpu_rd_gnt_cycle",  32'(cpu_gnt_cyc),  32'(c0 + 1));
        check("cpu_rd_done_cycle", 32'(cpu_done_cyc), 32'(c0 + 3));
        check("cpu_rd_mem_en_cnt", 32'(mem_en_cnt),   32'd1);
        check("cpu_rd_data",       cpu_rdata,         32'hDEADBEEF);

        // Loader write then CPU readback.
        do_txn(1'b1, 1'b1, 32'h20, 32'h1234, c0);
        check("ldr_wr_gnt_cycle",  32'(ldr_gnt_cyc),  32'(c0 + 1));
        check("ldr_wr_we_cycle",   32'(mem_we_cyc),   32'(c0 + 1));
        check("ldr_wr_done_cycle", 32'(ldr_done_cyc), 32'(c0 + 1 + LAT));
        do_txn(1'b0, 1'b0, 32'h20, 32'h0, c0);
        check("cpu_readback", cpu_rdata, 32'h00001234);

        // Loader request raised while the CPU access is in WAIT.
        c0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        tick();
        cpu_req = 1'b0;
        tick();
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h10;
        repeat (3) tick();
        ldr_req = 1'b0;
        repeat (LAT + 1) tick();
        check("held_off_gap",      32'(ldr_gnt_cyc - cpu_done_cyc), 32'd2);
        check("held_off_gnt_cyc",  32'(ldr_gnt_cyc), 32'(c0 + LAT + 3));
        check("held_off_ldr_data", ldr_rdata, 32'hDEADBEEF);

        // Reset while in WAIT.
        c0 = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        tick();
        cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_vec("abort_outputs", act_vec(), 160'd0);
        repeat (3) tick();
        check("abort_no_done", 32'(cpu_done_cyc > c0), 32'd0);
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, c0);
        check("after_abort_gnt",  32'(cpu_gnt_cyc), 32'(c0 + 1));
        check("after_abort_data", cpu_rdata, 32'hDEADBEEF);

        // Latency-1 instance: address change after gnt must not reach memory.
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h44;
        tick();
        check("lat1_gnt",      32'(c1_gnt), 32'd1);
        check("lat1_mem_en",   32'(m1_en),  32'd1);
        check("lat1_addr_acc", m1_addr,     32'h44);
        c1_req = 1'b0;
        c1_addr = 32'h99;
        tick();
        check("lat1_done",      32'(c1_done), 32'd1);
        check("lat1_addr_resp", m1_addr,      32'h44);
        check("lat1_rdata",     c1_rdata,     32'hCAFE0044);
        check("lat1_ldr_quiet", 32'({l1_gnt, l1_done, m1_we} | 3'(|l1_rdata) | 3'(|m1_wdata)), 32'd0);
        tick();
        check("lat1_done_pulse", 32'(c1_done), 32'd0);
        check("lat1_rdata_hold", c1_rdata,     32'hCAFE0044);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
